// File: rtl/cache_requester_if.sv
// Cache request bus between the memory-stage requester (master) and the cache (slave).
// req_operation / req_size carry the memory_operation_e / memory_operation_size_e encodings.
interface cache_requester_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] req_address;
  logic            req_operation;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_store_word;
  logic            req_valid;
  logic [XLEN-1:0] req_loaded_word;
  logic            req_fulfilled;

  modport master (
    output req_address, req_operation, req_size, req_store_word, req_valid,
    input  req_loaded_word, req_fulfilled
  );
  modport slave (
    input  req_address, req_operation, req_size, req_store_word, req_valid,
    output req_loaded_word, req_fulfilled
  );
endinterface

// File: rtl/cache_requester.sv
// Memory-stage request master: validates alignment, holds one cache request until fulfilled or
// aborted by the watchdog, then returns an extended load result or a completion/error response.
package cache_requester_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
endpackage

module cache_requester
  import cache_requester_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  input  memory_operation_e      op_operation_i,
  input  memory_operation_size_e op_size_i,
  input  logic                   op_unsigned_i,
  input  logic [XLEN-1:0]        op_address_i,
  input  logic [XLEN-1:0]        op_store_data_i,
  output logic                   rsp_valid_o,
  output logic [XLEN-1:0]        rsp_load_data_o,
  output logic                   rsp_misaligned_o,
  output logic                   rsp_timeout_o,
  cache_requester_if.master      req
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   mis_q, mis_d, to_q, to_d;
  logic [XLEN-1:0]        addr_q, wdata_q, rdata_q;
  memory_operation_e      op_q;
  memory_operation_size_e size_q;
  logic                   uns_q;
  logic                   accept, misaligned, capture_op, capture_rd;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [XLEN-1:0]        ext;

  assign op_ready_o = (state_q == IDLE) && !reset;
  assign accept     = op_valid_i && op_ready_o;
  assign misaligned = ((op_size_i == HALF) && op_address_i[0]) ||
                      ((op_size_i == WORD) && (op_address_i[1:0] != 2'b00));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    to_d       = to_q;
    capture_op = 1'b0;
    capture_rd = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        mis_d = misaligned;
        to_d  = 1'b0;
        cnt_d = '0;
        if (misaligned) state_d = RESP;
        else begin
          capture_op = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        // fulfilment takes priority over a watchdog expiry in the same cycle
        if (req.req_fulfilled) begin
          capture_rd = 1'b1;
          state_d    = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= LOAD;
      size_q  <= WORD;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      if (capture_op) begin
        addr_q  <= op_address_i;
        wdata_q <= op_store_data_i;
        op_q    <= op_operation_i;
        size_q  <= op_size_i;
        uns_q   <= op_unsigned_i;
      end
      if (capture_rd) rdata_q <= req.req_loaded_word;
    end
  end

  // cache returns the whole aligned word; pick the addressed lane and extend
  always_comb begin
    lane_b = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = rdata_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      BYTE:    ext = {{(XLEN-8){~uns_q & lane_b[7]}}, lane_b};
      HALF:    ext = {{(XLEN-16){~uns_q & lane_h[15]}}, lane_h};
      default: ext = rdata_q;
    endcase
  end

  assign rsp_valid_o      = (state_q == RESP);
  assign rsp_misaligned_o = rsp_valid_o && mis_q;
  assign rsp_timeout_o    = rsp_valid_o && to_q;
  assign rsp_load_data_o  = (rsp_valid_o && !mis_q && !to_q && (op_q == LOAD)) ? ext : '0;

  assign req.req_valid      = (state_q == REQ);
  assign req.req_address    = addr_q;
  assign req.req_operation  = op_q;
  assign req.req_size       = size_q;
  assign req.req_store_word = wdata_q;
endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: table of ops driven against a small cache model, responses
// checked from a scoreboard queue, plus hand sequences for reset and spurious fulfils.
module tb_cache_requester;
  import cache_requester_pkg::*;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  typedef struct {
    string                  name;
    memory_operation_e      op;
    memory_operation_size_e size;
    logic                   uns;
    logic [31:0]            addr;
    logic [31:0]            wdata;
    logic [31:0]            word;
    int                     k;      // cycle (1-based in REQ) the cache fulfils; 0 = never
    logic [31:0]            exp_data;
    logic                   exp_mis;
    logic                   exp_to;
    int                     exp_n;  // expected number of req_valid cycles
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        to;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   op_valid = 1'b0;
  logic                   op_ready;
  memory_operation_e      op_operation = LOAD;
  memory_operation_size_e op_size = WORD;
  logic                   op_unsigned = 1'b0;
  logic [XLEN-1:0]        op_address = '0;
  logic [XLEN-1:0]        op_store_data = '0;
  logic                   rsp_valid;
  logic [XLEN-1:0]        rsp_load_data;
  logic                   rsp_misaligned;
  logic                   rsp_timeout;

  int   checks = 0;
  int   failures = 0;
  int   rsp_count = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cache_requester_if #(.XLEN(XLEN)) cif ();

  cache_requester #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .op_valid_i       (op_valid),
    .op_ready_o       (op_ready),
    .op_operation_i   (op_operation),
    .op_size_i        (op_size),
    .op_unsigned_i    (op_unsigned),
    .op_address_i     (op_address),
    .op_store_data_i  (op_store_data),
    .rsp_valid_o      (rsp_valid),
    .rsp_load_data_o  (rsp_load_data),
    .rsp_misaligned_o (rsp_misaligned),
    .rsp_timeout_o    (rsp_timeout),
    .req              (cif)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // response monitor: every rsp_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected got=rsp_valid expected=none @%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_load_data, e.data);
        chk("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, e.mis});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
      end
    end
  end

  task automatic run_op(input vec_t v);
    int n;
    int g;
    g = 0;
    while (!op_ready && g < 50) begin
      step();
      g++;
    end
    chk({v.name, ":ready"}, {31'b0, op_ready}, 32'd1);
    op_valid      = 1'b1;
    op_operation  = v.op;
    op_size       = v.size;
    op_unsigned   = v.uns;
    op_address    = v.addr;
    op_store_data = v.wdata;
    sb.push_back('{v.exp_data, v.exp_mis, v.exp_to});
    step();
    op_valid      = 1'b0;
    op_address    = $urandom;
    op_store_data = $urandom;
    n = 0;
    while (cif.req_valid && n < 20) begin
      n++;
      chk({v.name, ":req_addr"}, cif.req_address, v.addr);
      chk({v.name, ":req_op"}, {31'b0, cif.req_operation}, 32'(v.op));
      chk({v.name, ":req_size"}, {30'b0, cif.req_size}, 32'(v.size));
      chk({v.name, ":req_wdata"}, cif.req_store_word, v.wdata);
      if (n == v.k) begin
        cif.req_fulfilled   = 1'b1;
        cif.req_loaded_word = v.word;
      end else begin
        cif.req_loaded_word = $urandom;
      end
      step();
      cif.req_fulfilled = 1'b0;
    end
    chk({v.name, ":req_cycles"}, 32'(n), 32'(v.exp_n));
    chk({v.name, ":busy_in_resp"}, {31'b0, op_ready}, 32'd0);
    step();
    chk({v.name, ":ready_again"}, {31'b0, op_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    cif.req_fulfilled   = 1'b0;
    cif.req_loaded_word = '0;

    vecs.push_back('{"word_load",    LOAD,  WORD, 1'b0, 32'h100, 32'hA5A5A5A5, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 1'b0, 3});
    vecs.push_back('{"byte_s_103",   LOAD,  BYTE, 1'b0, 32'h103, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'hFFFFFF80, 1'b0, 1'b0, 1});
    vecs.push_back('{"byte_u_103",   LOAD,  BYTE, 1'b1, 32'h103, 32'hA5A5A5A5, 32'h80F17F22, 2, 32'h00000080, 1'b0, 1'b0, 2});
    vecs.push_back('{"half_s_102",   LOAD,  HALF, 1'b0, 32'h102, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'hFFFF80F1, 1'b0, 1'b0, 1});
    vecs.push_back('{"half_u_100",   LOAD,  HALF, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'h00007F22, 1'b0, 1'b0, 1});
    vecs.push_back('{"byte_u_101",   LOAD,  BYTE, 1'b1, 32'h101, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'h0000007F, 1'b0, 1'b0, 1});
    vecs.push_back('{"byte_s_102",   LOAD,  BYTE, 1'b0, 32'h102, 32'hA5A5A5A5, 32'h80F17F22, 2, 32'hFFFFFFF1, 1'b0, 1'b0, 2});
    vecs.push_back('{"half_s_100",   LOAD,  HALF, 1'b0, 32'h100, 32'hA5A5A5A5, 32'h12348000, 1, 32'hFFFF8000, 1'b0, 1'b0, 1});
    vecs.push_back('{"store_word",   STORE, WORD, 1'b0, 32'h200, 32'h12345678, 32'hCAFEF00D, 2, 32'h00000000, 1'b0, 1'b0, 2});
    vecs.push_back('{"store_byte",   STORE, BYTE, 1'b0, 32'h203, 32'h000000AB, 32'hCAFEF00D, 1, 32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{"mis_half_101", LOAD,  HALF, 1'b0, 32'h101, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{"mis_word_102", LOAD,  WORD, 1'b0, 32'h102, 32'hA5A5A5A5, 32'h80F17F22, 1, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{"mis_store",    STORE, WORD, 1'b0, 32'h201, 32'h11111111, 32'h80F17F22, 1, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{"timeout",      LOAD,  WORD, 1'b0, 32'h300, 32'hA5A5A5A5, 32'h55555555, 0, 32'h00000000, 1'b0, 1'b1, 4});
    vecs.push_back('{"fulfil_last",  LOAD,  WORD, 1'b0, 32'h304, 32'hA5A5A5A5, 32'h11223344, 4, 32'h11223344, 1'b0, 1'b0, 4});

    // reset state
    step();
    step();
    chk("rst:op_ready", {31'b0, op_ready}, 32'd0);
    chk("rst:req_valid", {31'b0, cif.req_valid}, 32'd0);
    chk("rst:rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst:rsp_flags", {30'b0, rsp_misaligned, rsp_timeout}, 32'd0);
    chk("rst:rsp_data", rsp_load_data, 32'd0);
    chk("rst:req_addr", cif.req_address, 32'd0);
    chk("rst:req_wdata", cif.req_store_word, 32'd0);
    chk("rst:req_op", {31'b0, cif.req_operation}, 32'(LOAD));
    chk("rst:req_size", {30'b0, cif.req_size}, 32'(WORD));
    reset = 1'b0;
    step();
    chk("rst:ready_after", {31'b0, op_ready}, 32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // fulfil pulses while idle must be ignored
    cnt = rsp_count;
    cif.req_fulfilled   = 1'b1;
    cif.req_loaded_word = 32'hBADBADBA;
    step();
    step();
    cif.req_fulfilled = 1'b0;
    step();
    chk("spur:no_rsp", 32'(rsp_count), 32'(cnt));
    chk("spur:ready", {31'b0, op_ready}, 32'd1);
    chk("spur:req_valid", {31'b0, cif.req_valid}, 32'd0);

    // reset while a request is outstanding drops it without a response
    cnt = rsp_count;
    op_valid     = 1'b1;
    op_operation = LOAD;
    op_size      = WORD;
    op_address   = 32'h400;
    step();
    op_valid = 1'b0;
    chk("rreq:req_valid", {31'b0, cif.req_valid}, 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("rreq:req_valid_drop", {31'b0, cif.req_valid}, 32'd0);
    chk("rreq:ready_in_reset", {31'b0, op_ready}, 32'd0);
    chk("rreq:addr_discarded", cif.req_address, 32'd0);
    reset = 1'b0;
    step();
    chk("rreq:ready_after", {31'b0, op_ready}, 32'd1);
    step();
    chk("rreq:no_rsp", 32'(rsp_count), 32'(cnt));

    run_op(vecs[0]);
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_requester.md
Name: cache_requester

Overview:
- Initiator-side master for the cache request interface. It is the load/store side that drives `req_address`, `req_operation`, `req_size`, `req_store_word` and `req_valid`, and consumes `req_loaded_word` and `req_fulfilled`.
- Accepts one memory op at a time from the pipeline memory stage and checks alignment.
- Holds the cache request stable until fulfilled, then returns a load result (byte/half extracted, sign- or zero-extended) or a completion/error response.
- A watchdog aborts requests the cache never fulfils.

Parameters:
XLEN, 32, data/address width; must match the cache interface.
TIMEOUT_CYCLES, 256, max REQ cycles before abort; 0 disables the watchdog.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
op_valid  input  1  pipeline presents an op
op_ready  output  1  block can accept an op
op_operation  input  memory_operation_e  LOAD or STORE
op_size  input  memory_operation_size_e  BYTE, HALF or WORD
op_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
op_address  input  XLEN  byte address
op_store_data  input  XLEN  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse
rsp_load_data  output  XLEN  extended load result; 0 for stores and errors
rsp_misaligned  output  1  valid with rsp_valid
rsp_timeout  output  1  valid with rsp_valid
req_address  output  XLEN  to cache
req_operation  output  memory_operation_e  to cache
req_size  output  memory_operation_size_e  to cache
req_store_word  output  XLEN  to cache, right-aligned store data
req_valid  output  1  to cache
req_loaded_word  input  XLEN  from cache: full aligned word containing req_address
req_fulfilled  input  1  from cache

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - req_valid=0, rsp_valid=0, rsp_misaligned=0, rsp_timeout=0, rsp_load_data=0.
  - req_address=0, req_store_word=0, req_operation=LOAD, req_size=WORD.
  - Watchdog counter=0.
  - op_ready=0 while reset is high.
- op_ready = (state==IDLE) && !reset. An op is accepted on a cycle with op_valid && op_ready.
- Misalignment: HALF with address[0]!=0, or WORD with address[1:0]!=0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On accept of an aligned op: register all op fields; go to REQ. req_valid=1 from the next cycle.
  - On accept of a misaligned op: go to RESP with misaligned flag set. The cache is never requested.
- REQ:
  - req_valid=1; all req_* outputs are held stable.
  - Watchdog counter increments every cycle in REQ; it is cleared on REQ entry.
  - req_fulfilled=1: capture req_loaded_word, go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: go to RESP with timeout flag set.
  - Fulfilled and timeout on the same cycle: fulfilled wins; no timeout.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_valid=0; then go to IDLE.
  - No backpressure on the response.
- Load extraction, with a = address[1:0]:
  - BYTE: byte lane a.
  - HALF: half lane a[1].
  - WORD: whole word.
  - Sign-extend to XLEN unless op_unsigned.
  - Stores, misaligned and timeout responses: rsp_load_data=0.
- Latency (op accepted at cycle 0):
  - req_valid high from cycle 1.
  - req_fulfilled at cycle k (k>=1) gives rsp_valid at k+1, and op_ready again at k+2.
  - Misaligned op: rsp_valid at cycle 1.
  - Back-to-back issue rate: one op per k+2 cycles.
- req_fulfilled outside REQ (IDLE/RESP) is ignored; no state change, no capture.
- Reset mid-operation (REQ or RESP) returns to IDLE next cycle:
  - req_valid drops; no response is emitted; the captured op is discarded.
- rsp_misaligned and rsp_timeout are never both 1.

Test Plan:
- Word load: addr=0x100, cache fulfils at cycle 3 with 0xDEADBEEF. Expect req_valid cycles 1-3 with stable fields, rsp_valid at cycle 4 with rsp_load_data=0xDEADBEEF, op_ready=1 at cycle 5.
- Byte/half extension: loaded word 0x80F17F22.
  - BYTE signed addr=0x103: 0xFFFFFF80.
  - BYTE unsigned addr=0x103: 0x00000080.
  - HALF signed addr=0x102: 0xFFFF80F1.
  - HALF unsigned addr=0x100: 0x00007F22.
- Store WORD data=0x12345678 to 0x200. Expect req_operation=STORE, req_store_word=0x12345678; after fulfil, rsp_valid with rsp_load_data=0 and both flags 0.
- Misaligned: HALF at 0x101 and WORD at 0x102. Expect req_valid never asserted, rsp_valid at cycle 1 with rsp_misaligned=1.
- Watchdog: TIMEOUT_CYCLES=4, cache silent. Expect req_valid high exactly 4 cycles, then rsp_valid with rsp_timeout=1.
  - Repeat with fulfil on the 4th cycle: expect normal response, rsp_timeout=0.
- Spurious/reset cases:
  - req_fulfilled pulsed in IDLE: no rsp_valid.
  - reset asserted during REQ: req_valid=0 the cycle after, no response, op_ready=1 after reset deasserts.
